axi4l_gpio_slave: RTL and testbench

AXI4-Lite slave front-end of the GPIO block; consumes transactions driven on the AXI4-Lite bus by the agent/master and maps them onto a small GPIO register file. Drives pad outputs and output enables, samples pad inputs through a 2-flop synchronizer, and raises a level interrupt on enabled rising edges. Sits directly downstream of the AXI4-Lite bus interface.

---
 rtl/axi4l_gpio_slave.sv | 168 ++++++++++++++++
 tb/tb_axi4l_gpio_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_gpio_slave.sv
// AXI4-Lite slave for a small GPIO block: pad data/direction registers,
// synchronized pad inputs and rising-edge interrupts with W1C status.
module axi4l_gpio_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  input  logic [GPIO_WIDTH-1:0]   gpio_in,
  output logic [GPIO_WIDTH-1:0]   gpio_out,
  output logic [GPIO_WIDTH-1:0]   gpio_oe,
  output logic                    irq
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] OFF_DOUT = 8'h00;
  localparam logic [7:0] OFF_DIR  = 8'h04;
  localparam logic [7:0] OFF_DIN  = 8'h08;
  localparam logic [7:0] OFF_IEN  = 8'h0C;
  localparam logic [7:0] OFF_IST  = 8'h10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_WRESP, ST_RDATA} state_t;

  state_t                state;
  logic                  idle_rdy;
  logic [7:0]            awoff;
  logic [GPIO_WIDTH-1:0] data_out, dir, irq_en, irq_status;
  logic [GPIO_WIDTH-1:0] sync1, sync2, sync3;

  logic [DATA_WIDTH-1:0] strb_mask_c;
  logic [GPIO_WIDTH-1:0] wmask_c, wval_c, clr_c, set_c;
  logic                  wr_fire_c, wr_err_c, rd_err_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  unused_ok;

  assign unused_ok = &{1'b0, AWADDR, ARADDR, WDATA};

  // Write handshake is only offered when idle; a simultaneous AR waits a cycle.
  assign AWREADY  = idle_rdy;
  assign ARREADY  = idle_rdy & ~AWVALID;
  assign gpio_out = data_out;
  assign gpio_oe  = dir;

  always_comb begin
    strb_mask_c = '0;
    for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
      strb_mask_c[b*8 +: 8] = {8{WSTRB[b]}};
    end
  end

  assign wmask_c   = strb_mask_c[GPIO_WIDTH-1:0];
  assign wval_c    = WDATA[GPIO_WIDTH-1:0] & wmask_c;
  assign wr_fire_c = (state == ST_WDATA) && WVALID;
  assign wr_err_c  = !(awoff inside {OFF_DOUT, OFF_DIR, OFF_IEN, OFF_IST});
  assign clr_c     = (wr_fire_c && (awoff == OFF_IST)) ? wval_c : '0;
  assign set_c     = sync2 & ~sync3 & irq_en;

  // Read mux, sampled into RDATA at the AR handshake.
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (ARADDR[7:0])
      OFF_DOUT: rd_data_c = DATA_WIDTH'(data_out);
      OFF_DIR:  rd_data_c = DATA_WIDTH'(dir);
      OFF_DIN:  rd_data_c = DATA_WIDTH'(sync2);
      OFF_IEN:  rd_data_c = DATA_WIDTH'(irq_en);
      OFF_IST:  rd_data_c = DATA_WIDTH'(irq_status);
      default:  rd_err_c  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idle_rdy   <= 1'b0;
      awoff      <= '0;
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_status <= '0;
      sync1      <= '0;
      sync2      <= '0;
      sync3      <= '0;
      irq        <= 1'b0;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= RESP_OKAY;
      RVALID     <= 1'b0;
      RRESP      <= RESP_OKAY;
      RDATA      <= '0;
    end else begin
      sync1      <= gpio_in;
      sync2      <= sync1;
      sync3      <= sync2;
      // A set on the same cycle as a W1C clear wins.
      irq_status <= (irq_status & ~clr_c) | set_c;
      irq        <= |irq_status;

      case (state)
        ST_IDLE: begin
          idle_rdy <= 1'b1;
          if (idle_rdy && AWVALID) begin
            awoff    <= AWADDR[7:0];
            idle_rdy <= 1'b0;
            WREADY   <= 1'b1;
            state    <= ST_WDATA;
          end else if (idle_rdy && ARVALID) begin
            RDATA    <= rd_data_c;
            RRESP    <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
            RVALID   <= 1'b1;
            idle_rdy <= 1'b0;
            state    <= ST_RDATA;
          end
        end
        ST_WDATA: begin
          if (WVALID) begin
            WREADY <= 1'b0;
            BVALID <= 1'b1;
            BRESP  <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
            state  <= ST_WRESP;
            case (awoff)
              OFF_DOUT: data_out <= (data_out & ~wmask_c) | wval_c;
              OFF_DIR:  dir      <= (dir & ~wmask_c) | wval_c;
              OFF_IEN:  irq_en   <= (irq_en & ~wmask_c) | wval_c;
              default:  ;
            endcase
          end
        end
        ST_WRESP: begin
          if (BREADY) begin
            BVALID   <= 1'b0;
            idle_rdy <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_RDATA: begin
          if (RREADY) begin
            RVALID   <= 1'b0;
            idle_rdy <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_gpio_slave.sv
// Randomized bench for axi4l_gpio_slave against a transaction-level model of
// the register file, pad-input history and interrupt rules.
module tb_axi4l_gpio_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic [15:0] gpio_in, gpio_out, gpio_oe;
  logic        irq;

  int total = 0;
  int bad   = 0;

  axi4l_gpio_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .GPIO_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_out, m_dir, m_en, m_st;
  logic        m_irq, m_bvalid, m_rvalid;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [7:0]  m_awoff;
  logic [15:0] hist[$];

  // Pad value as sampled k clock edges ago (0 before reset history exists).
  function automatic logic [15:0] past(input int k);
    if (hist.size() >= k) return hist[hist.size()-k];
    return 16'h0;
  endfunction

  function automatic logic [33:0] m_read(input logic [7:0] off);
    case (off)
      8'h00:   return {2'b00, 16'h0, m_out};
      8'h04:   return {2'b00, 16'h0, m_dir};
      8'h08:   return {2'b00, 16'h0, past(2)};
      8'h0C:   return {2'b00, 16'h0, m_en};
      8'h10:   return {2'b00, 16'h0, m_st};
      default: return {2'b10, 32'h0};
    endcase
  endfunction

  initial begin
    logic [15:0] msk, wv, setb, clr;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_out = 0; m_dir = 0; m_en = 0; m_st = 0; m_irq = 0;
        m_bvalid = 0; m_rvalid = 0; m_bresp = 0; m_rresp = 0; m_rdata = 0;
        m_awoff = 0;
        hist.delete();
      end else begin
        setb  = past(2) & ~past(3) & m_en;
        clr   = 16'h0;
        m_irq = |m_st;
        if (ARVALID && ARREADY) begin
          {m_rresp, m_rdata} = m_read(ARADDR[7:0]);
          m_rvalid = 1'b1;
        end else if (m_rvalid && RREADY) begin
          m_rvalid = 1'b0;
        end
        if (AWVALID && AWREADY) m_awoff = AWADDR[7:0];
        if (WVALID && WREADY) begin
          msk = {{8{WSTRB[1]}}, {8{WSTRB[0]}}};
          wv  = WDATA[15:0] & msk;
          case (m_awoff)
            8'h00:   m_out = (m_out & ~msk) | wv;
            8'h04:   m_dir = (m_dir & ~msk) | wv;
            8'h0C:   m_en  = (m_en & ~msk) | wv;
            8'h10:   clr   = wv;
            default: ;
          endcase
          m_bresp  = (m_awoff inside {8'h00, 8'h04, 8'h0C, 8'h10}) ? 2'b00 : 2'b10;
          m_bvalid = 1'b1;
        end else if (m_bvalid && BREADY) begin
          m_bvalid = 1'b0;
        end
        m_st = (m_st & ~clr) | setb;
        hist.push_back(gpio_in);
        if (hist.size() > 4) void'(hist.pop_front());
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("gpio_out", 32'(gpio_out), 32'(m_out));
        chk("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("bvalid", 32'(BVALID), 32'(m_bvalid));
        chk("rvalid", 32'(RVALID), 32'(m_rvalid));
        if (BVALID) chk("bresp", 32'(BRESP), 32'(m_bresp));
        if (RVALID) begin
          chk("rdata", RDATA, m_rdata);
          chk("rresp", 32'(RRESP), 32'(m_rresp));
        end
      end
    end
  end

  // ---------------- bus tasks (start and end #1 after a rising edge) ----------------
  task automatic wait_ready(input logic is_aw, input string nm);
    int n = 0;
    @(negedge clk);
    while (!(is_aw ? AWREADY : ARREADY) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(is_aw ? AWREADY : ARREADY), 32'd1);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] r);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    wait_ready(1'b1, "awready_wait");
    @(posedge clk); #1 AWVALID = 1'b0;
    @(negedge clk); chk("wready_latency", 32'(WREADY), 32'd1);
    @(posedge clk); #1 WVALID = 1'b0;
    @(negedge clk); chk("bvalid_latency", 32'(BVALID), 32'd1);
    r = BRESP;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("bvalid_hold", 32'(BVALID), 32'd1);
      chk("bresp_hold", 32'(BRESP), 32'(r));
    end
    BREADY = 1'b1;
    @(posedge clk); #1 BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r);
    ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
    wait_ready(1'b0, "arready_wait");
    @(posedge clk); #1 ARVALID = 1'b0;
    @(negedge clk); chk("rvalid_latency", 32'(RVALID), 32'd1);
    d = RDATA; r = RRESP;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("rvalid_hold", 32'(RVALID), 32'd1);
      chk("rdata_hold", RDATA, d);
      chk("rresp_hold", 32'(RRESP), 32'(r));
    end
    RREADY = 1'b1;
    @(posedge clk); #1 RREADY = 1'b0;
  endtask

  logic [7:0] offs [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  r;
    int          hold, op, n;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40, 8'hFC};
    AWADDR = 0; WDATA = 0; WSTRB = 0; AWVALID = 0; WVALID = 0; BREADY = 0;
    ARADDR = 0; ARVALID = 0; RREADY = 0; gpio_in = 0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // Registers read back zero after reset.
    for (int i = 0; i < 5; i++) begin
      if (i == 2) continue;
      axi_read(32'(offs[i]), 0, d, r);
      chk("t1_rdata", d, 32'h0);
      chk("t1_rresp", 32'(r), 32'd0);
    end
    chk("t1_oe", 32'(gpio_oe), 32'h0);

    // Direction, data out and byte-lane masking.
    axi_write(32'h04, 32'h0000_FFFF, 4'hF, 0, r);
    chk("t2_bresp_dir", 32'(r), 32'd0);
    axi_write(32'h00, 32'h0000_A5A5, 4'hF, 0, r);
    chk("t2_bresp_out", 32'(r), 32'd0);
    chk("t2_oe", 32'(gpio_oe), 32'hFFFF);
    chk("t2_out", 32'(gpio_out), 32'hA5A5);
    axi_write(32'h00, 32'h0000_3C00, 4'h2, 0, r);
    chk("t2_out_strb", 32'(gpio_out), 32'h3CA5);

    // Synchronized input and read-only DATA_IN.
    gpio_in = 16'h0081;
    repeat (3) @(posedge clk);
    #1;
    axi_read(32'h08, 0, d, r);
    chk("t3_din", d, 32'h0000_0081);
    axi_write(32'h08, 32'h0000_FFFF, 4'hF, 0, r);
    chk("t3_din_wr_bresp", 32'(r), 32'd2);
    axi_read(32'h08, 0, d, r);
    chk("t3_din_after_wr", d, 32'h0000_0081);

    // Rising-edge interrupt, W1C clear, and set-over-clear.
    gpio_in = 16'h0;
    repeat (4) @(posedge clk);
    #1;
    axi_write(32'h0C, 32'h1, 4'hF, 0, r);
    gpio_in = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("t4_irq_pre", 32'(irq), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("t4_irq_set", 32'(irq), 32'd1);
    @(posedge clk); #1;
    axi_read(32'h10, 0, d, r);
    chk("t4_status", d, 32'h1);
    axi_write(32'h10, 32'h1, 4'hF, 0, r);
    @(negedge clk); chk("t4_irq_clr", 32'(irq), 32'd0);
    @(posedge clk); #1;
    gpio_in = 16'h0;
    repeat (4) @(posedge clk);
    #1 gpio_in = 16'h0001;
    repeat (4) @(posedge clk);
    #1 gpio_in = 16'h0;
    repeat (4) @(posedge clk);
    #1 gpio_in = 16'h0001;
    @(posedge clk); #1;
    axi_write(32'h10, 32'h1, 4'hF, 0, r);
    axi_read(32'h10, 0, d, r);
    chk("t4_set_wins", d, 32'h1);
    chk("t4_irq_held", 32'(irq), 32'd1);

    // Unmapped accesses, upper address bits, response back-pressure.
    axi_read(32'h14, 5, d, r);
    chk("t5_rd14_data", d, 32'h0);
    chk("t5_rd14_resp", 32'(r), 32'd2);
    axi_read(32'h40, 5, d, r);
    chk("t5_rd40_data", d, 32'h0);
    chk("t5_rd40_resp", 32'(r), 32'd2);
    axi_write(32'h14, 32'hFFFF_FFFF, 4'hF, 5, r);
    chk("t5_wr14_resp", 32'(r), 32'd2);
    axi_write(32'hABCD_EF04, 32'h0000_00F0, 4'h1, 5, r);
    chk("t5_upper_resp", 32'(r), 32'd0);
    chk("t5_upper_oe", 32'(gpio_oe), 32'hFFF0);

    // Randomized traffic checked by the model.
    for (int i = 0; i < 200; i++) begin
      op   = int'($urandom_range(0, 9));
      a    = ($urandom & 32'hFFFF_FF00) | 32'(offs[$urandom_range(0, 7)]);
      hold = int'($urandom_range(0, 3));
      if (op < 4) begin
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), hold, r);
      end else if (op < 8) begin
        axi_read(a, hold, d, r);
      end else begin
        gpio_in = 16'($urandom);
        n = int'($urandom_range(0, 4));
        repeat (n) begin @(posedge clk); #1; end
      end
    end

    // Reset while a write response is pending.
    axi_write(32'h04, 32'h0000_FFFF, 4'hF, 0, r);
    AWADDR = 32'h0; WDATA = 32'h0000_1234; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b0;
    wait_ready(1'b1, "t6_awready_wait");
    @(posedge clk); #1 AWVALID = 1'b0;
    @(posedge clk); #1 WVALID = 1'b0;
    @(negedge clk);
    chk("t6_bvalid_before", 32'(BVALID), 32'd1);
    chk("t6_out_before", 32'(gpio_out), 32'h1234);
    #2 rst = 1'b0;
    #1;
    chk("t6_bvalid_rst", 32'(BVALID), 32'd0);
    chk("t6_out_rst", 32'(gpio_out), 32'h0);
    chk("t6_oe_rst", 32'(gpio_oe), 32'h0);
    chk("t6_irq_rst", 32'(irq), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) continue;
      axi_read(32'(offs[i]), 0, d, r);
      chk("t6_rdata", d, 32'h0);
      chk("t6_rresp", 32'(r), 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
